// File: rtl/linebuf_scanout_if.sv
// Line-buffer side of the scanout block: per-line start/vline to gfx and the
// read port into the finished line buffer.
//
// Handshake: there is no backpressure. start is a one-clock pulse and vline is
// only meaningful while start=1 (it holds its last value otherwise). The
// scanout drives linebuf_rdidx every clock, and the buffer must present the
// entry for that index on linebuf_data exactly one clock later.
interface linebuf_scanout_if;
  logic [7:0] vline;
  logic       start;
  logic [7:0] linebuf_rdidx;
  logic [4:0] linebuf_data;

  modport master (
    output vline,
    output start,
    output linebuf_rdidx,
    input  linebuf_data
  );

  modport slave (
    input  vline,
    input  start,
    input  linebuf_rdidx,
    output linebuf_data
  );
endinterface

// File: rtl/linebuf_scanout.sv
// linebuf_scanout: read side of the gfx line buffer.
// Generates pixel/line timing, requests each line from gfx one line ahead,
// reads the finished line and resolves 5-bit entries through a 32x6 colour RAM.
// Pipeline: stage0 counters/rdidx, stage1 linebuf data + CRAM address,
// stage2 registered CRAM data with de/hsync/vsync aligned to it.
// Optional feature: define SCANOUT_LINE_IRQ_EN to build the line interrupt
// down-counter; without it line_irq is tied low.
module linebuf_scanout #(
  parameter int H_ACTIVE   = 256,
  parameter int H_TOTAL    = 342,
  parameter int H_SYNC_ST  = 280,
  parameter int H_SYNC_LEN = 26,
  parameter int V_ACTIVE   = 192,
  parameter int V_TOTAL    = 262,
  parameter int V_SYNC_ST  = 224,
  parameter int V_SYNC_LEN = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     display_en,
  input  logic                     mask_col0,
  input  logic [3:0]               bgcol,
  input  logic [4:0]               cram_wraddr,
  input  logic [5:0]               cram_wrdata,
  input  logic                     cram_wren,
  input  logic [7:0]               line_irq_reload,
  output logic                     line_irq,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  linebuf_scanout_if.master        lb
);

  // ---------------- stage0: counters and line requests ----------------
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] vnext;
  logic       start_d;
  logic [7:0] vline_d;

  assign h_wrap = (hcnt == 9'(H_TOTAL - 1));
  assign v_wrap = (vcnt == 9'(V_TOTAL - 1));
  assign vnext  = vcnt + 9'd1;

  // Request the next visible line; the last line of the frame requests line 0.
  assign start_d = (hcnt == 9'd0) && ((vnext < 9'(V_ACTIVE)) || v_wrap);
  assign vline_d = v_wrap ? 8'd0 : vnext[7:0];

  // Pixel and line counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= 9'd0;
      vcnt <= 9'd0;
    end else if (h_wrap) begin
      hcnt <= 9'd0;
      vcnt <= v_wrap ? 9'd0 : vnext;
    end else begin
      hcnt <= hcnt + 9'd1;
    end
  end

  // Registered start pulse; vline holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      lb.start <= 1'b0;
      lb.vline <= 8'd0;
    end else begin
      lb.start <= start_d;
      if (start_d) begin
        lb.vline <= vline_d;
      end
    end
  end

  assign lb.linebuf_rdidx = (hcnt < 9'(H_ACTIVE)) ? hcnt[7:0] : 8'd0;

  // Region flags decoded from the counters; syncs kept in active-low form.
  logic active0;
  logic col0_0;
  logic hs_n0;
  logic vs_n0;

  assign active0 = (hcnt < 9'(H_ACTIVE)) && (vcnt < 9'(V_ACTIVE));
  assign col0_0  = (hcnt < 9'd8);
  assign hs_n0   = !((hcnt >= 9'(H_SYNC_ST)) && (hcnt < 9'(H_SYNC_ST + H_SYNC_LEN)));
  assign vs_n0   = !((vcnt >= 9'(V_SYNC_ST)) && (vcnt < 9'(V_SYNC_ST + V_SYNC_LEN)));

  // ---------------- stage1: line data valid, choose CRAM address ----------------
  logic active1;
  logic col0_1;
  logic hs_n1;
  logic vs_n1;

  // Carry region flags alongside the one-clock line buffer read.
  always_ff @(posedge clk) begin
    if (reset) begin
      active1 <= 1'b0;
      col0_1  <= 1'b0;
      hs_n1   <= 1'b1;
      vs_n1   <= 1'b1;
    end else begin
      active1 <= active0;
      col0_1  <= col0_0;
      hs_n1   <= hs_n0;
      vs_n1   <= vs_n0;
    end
  end

  logic       use_border;
  logic [4:0] cram_rdaddr;

  assign use_border  = !active1 || !display_en || (mask_col0 && col0_1);
  assign cram_rdaddr = use_border ? {1'b1, bgcol} : lb.linebuf_data;

  // ---------------- colour RAM ----------------
  logic [5:0] cram [32];

  // CRAM write port; contents survive reset. A same-clock read sees the old value.
  always_ff @(posedge clk) begin
    if (cram_wren) begin
      cram[cram_wraddr] <= cram_wrdata;
    end
  end

  // ---------------- stage2: registered colour and aligned timing ----------------
  logic [5:0] rgb_q;

  // Colour is blanked outside the active area; timing flags follow the pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 6'd0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb_q <= active1 ? cram[cram_rdaddr] : 6'd0;
      de    <= active1;
      hsync <= hs_n1;
      vsync <= vs_n1;
    end
  end

  assign red   = {rgb_q[1:0], rgb_q[1:0]};
  assign green = {rgb_q[3:2], rgb_q[3:2]};
  assign blue  = {rgb_q[5:4], rgb_q[5:4]};

  // ---------------- line interrupt ----------------
`ifdef SCANOUT_LINE_IRQ_EN
  logic [7:0] irq_cnt;
  logic       irq_q;

  // Counter steps once per line at the end of the active span; line V_ACTIVE
  // still counts, later blanking lines keep it parked at the reload value.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_cnt <= line_irq_reload;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (hcnt == 9'(H_ACTIVE)) begin
        if (vcnt <= 9'(V_ACTIVE)) begin
          if (irq_cnt == 8'd0) begin
            irq_q   <= 1'b1;
            irq_cnt <= line_irq_reload;
          end else begin
            irq_cnt <= irq_cnt - 8'd1;
          end
        end else begin
          irq_cnt <= line_irq_reload;
        end
      end
    end
  end

  assign line_irq = irq_q;
`else
  logic unused_reload;
  assign unused_reload = ^line_irq_reload;
  assign line_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_linebuf_scanout.sv
// Bench for linebuf_scanout: one full frame of timing checks from reset with
// directed pixel/border/CRAM checks embedded, then a mid-line reset.
module tb_linebuf_scanout;
  localparam int HT    = 342;
  localparam int VT    = 262;
  localparam int FRAME = HT * VT;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       display_en = 1'b1;
  logic       mask_col0 = 1'b0;
  logic [3:0] bgcol = 4'd0;
  logic [4:0] cram_wraddr = 5'd0;
  logic [5:0] cram_wrdata = 6'd0;
  logic       cram_wren = 1'b0;
  logic [7:0] line_irq_reload = 8'd3;
  logic       line_irq;
  logic [3:0] red, green, blue;
  logic       hsync, vsync, de;

  always #5 clk = ~clk;

  linebuf_scanout_if lb_if ();

  linebuf_scanout dut (
    .clk             (clk),
    .reset           (reset),
    .display_en      (display_en),
    .mask_col0       (mask_col0),
    .bgcol           (bgcol),
    .cram_wraddr     (cram_wraddr),
    .cram_wrdata     (cram_wrdata),
    .cram_wren       (cram_wren),
    .line_irq_reload (line_irq_reload),
    .line_irq        (line_irq),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .hsync           (hsync),
    .vsync           (vsync),
    .de              (de),
    .lb              (lb_if.master)
  );

  // Line buffer model: fixed contents, one clock read latency.
  logic [4:0] lb_mem [256];
  always @(posedge clk) lb_if.linebuf_data <= lb_mem[lb_if.linebuf_rdidx];

  logic [5:0] cram_m [32];
  localparam logic [5:0] CRAM7_NEW = 6'b010101;
  logic [5:0] cram7_old;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0, start_bad = 0, rdidx_bad = 0;
  int hs_low = 0, hs_bad = 0, vs_low = 0, vs_bad = 0;
  int de_hi = 0, de_bad = 0, irq_cnt = 0, irq_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_of(input logic [5:0] c);
    return {c[1:0], c[1:0], c[3:2], c[3:2], c[5:4], c[5:4]};
  endfunction

  function automatic int px(input int x, input int v);
    return v * HT + x + 2;
  endfunction

  // Per-cycle timing model for cycle k of a frame started from reset.
  task automatic sample_frame(input int k);
    int h, hp, vp, h2, v2;
    logic exp_start, exp_hs, exp_vs, exp_de, exp_irq;
    h  = k % HT;
    hp = (k >= 1) ? (k - 1) % HT : -1;
    vp = (k >= 1) ? ((k - 1) / HT) % VT : -1;
    if (lb_if.linebuf_rdidx !== ((h < 256) ? 8'(h) : 8'd0)) rdidx_bad++;

    exp_start = (k >= 1) && (hp == 0) && ((vp + 1 < 192) || (vp == 261));
    if (lb_if.start !== exp_start) start_bad++;
    if (lb_if.start === 1'b1) begin
      start_cnt++;
      if (exp_q.size() > 0) check("vline", 32'(lb_if.vline), 32'(exp_q.pop_front()));
      else start_bad++;
    end

    if (k >= 2) begin
      h2 = (k - 2) % HT;
      v2 = ((k - 2) / HT) % VT;
      exp_hs = !((h2 >= 280) && (h2 < 306));
      exp_vs = !((v2 >= 224) && (v2 < 227));
      exp_de = (h2 < 256) && (v2 < 192);
    end else begin
      exp_hs = 1'b1;
      exp_vs = 1'b1;
      exp_de = 1'b0;
    end
    if (hsync !== exp_hs) hs_bad++;
    if (vsync !== exp_vs) vs_bad++;
    if (de !== exp_de) de_bad++;
    if (hsync === 1'b0) hs_low++;
    if (vsync === 1'b0) vs_low++;
    if (de === 1'b1) de_hi++;

`ifdef SCANOUT_LINE_IRQ_EN
    exp_irq = (k >= 1) && (hp == 256) && (vp % 4 == 3) && (vp <= 191);
`else
    exp_irq = 1'b0;
`endif
    if (line_irq !== exp_irq) irq_bad++;
    if (line_irq === 1'b1) irq_cnt++;
  endtask

  // Point checks at hand-picked pixels of the first frame.
  task automatic directed_checks(input int k);
    if (k == 0) begin
      check("rst_rgb", 32'({red, green, blue}), 32'h0);
      check("rst_de", 32'(de), 32'h0);
      check("rst_hsync", 32'(hsync), 32'h1);
      check("rst_vsync", 32'(vsync), 32'h1);
      check("rst_start", 32'(lb_if.start), 32'h0);
      check("rst_vline", 32'(lb_if.vline), 32'h0);
      check("rst_irq", 32'(line_irq), 32'h0);
    end
    if (k == 5 * HT + 10) check("rdidx_10_5", 32'(lb_if.linebuf_rdidx), 32'd10);
    if (k == px(10, 5)) check("pix_10_5", 32'({red, green, blue}), 32'hA5F);
    if (k == px(9, 5)) check("pix_9_5", 32'({red, green, blue}), 32'(rgb_of(cram_m[9])));
    if (k == px(255, 5)) check("de_255_5", 32'(de), 32'h1);
    if (k == px(256, 5)) begin
      check("de_256_5", 32'(de), 32'h0);
      check("pix_256_5", 32'({red, green, blue}), 32'h0);
    end
    if (k == px(0, 6)) check("mask_0_6", 32'({red, green, blue}), 32'hFFF);
    if (k == px(7, 6)) check("mask_7_6", 32'({red, green, blue}), 32'hFFF);
    if (k == px(8, 6)) check("mask_8_6", 32'({red, green, blue}), 32'(rgb_of(cram_m[8])));
    if (k == px(0, 7)) check("dis_0_7", 32'({red, green, blue}), 32'hFFF);
    if (k == px(8, 7)) check("dis_8_7", 32'({red, green, blue}), 32'hFFF);
    if (k == px(255, 7)) check("dis_255_7", 32'({red, green, blue}), 32'hFFF);
    if (k == px(7, 8)) check("cram_old_7_8", 32'({red, green, blue}), 32'(rgb_of(cram7_old)));
    if (k == px(7, 9)) check("cram_new_7_9", 32'({red, green, blue}), 32'(rgb_of(CRAM7_NEW)));
    if (k == px(10, 200)) check("vblank_rgb", 32'({red, green, blue}), 32'h0);
  endtask

  // Driver: CRAM load, config changes between lines, coincident CRAM write.
  task automatic drive_frame(input int k);
    if (k < 32) begin
      cram_wren   = 1'b1;
      cram_wraddr = 5'(k);
      cram_wrdata = cram_m[k];
    end else if (k == 32) begin
      cram_wren = 1'b0;
    end
    if (k == 6 * HT - 20) begin
      bgcol     = 4'h2;
      mask_col0 = 1'b1;
    end
    if (k == 7 * HT - 20) display_en = 1'b0;
    if (k == 8 * HT - 20) begin
      display_en = 1'b1;
      mask_col0  = 1'b0;
      bgcol      = 4'h0;
    end
    if (k == px(7, 8) - 1) begin
      cram_wren   = 1'b1;
      cram_wraddr = 5'd7;
      cram_wrdata = CRAM7_NEW;
    end
    if (k == px(7, 8)) cram_wren = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lb_mem[i] = 5'(i);
    lb_mem[10] = 5'h03;
    for (int i = 0; i < 32; i++) cram_m[i] = 6'(i * 13 + 5);
    cram_m[3]  = 6'b110110;
    cram_m[18] = 6'h3F;
    cram7_old  = cram_m[7];
    for (int v = 1; v < 192; v++) exp_q.push_back(8'(v));
    exp_q.push_back(8'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < FRAME; k++) begin
      sample_frame(k);
      directed_checks(k);
      drive_frame(k);
      @(negedge clk);
    end

    check("start_count", 32'(start_cnt), 32'd192);
    check("start_timing_errs", 32'(start_bad), 32'd0);
    check("vline_left", 32'(exp_q.size()), 32'd0);
    check("rdidx_errs", 32'(rdidx_bad), 32'd0);
    check("hsync_low_clks", 32'(hs_low), 32'(262 * 26));
    check("hsync_errs", 32'(hs_bad), 32'd0);
    check("vsync_low_clks", 32'(vs_low), 32'(3 * HT));
    check("vsync_errs", 32'(vs_bad), 32'd0);
    check("de_high_clks", 32'(de_hi), 32'(192 * 256));
    check("de_errs", 32'(de_bad), 32'd0);
`ifdef SCANOUT_LINE_IRQ_EN
    check("irq_pulses", 32'(irq_cnt), 32'd48);
`else
    check("irq_pulses", 32'(irq_cnt), 32'd0);
`endif
    check("irq_errs", 32'(irq_bad), 32'd0);

    // Run into frame 2 up to (100,10), then reset for one clock.
    repeat (10 * HT + 100) @(negedge clk);
    check("pre_rst_rdidx", 32'(lb_if.linebuf_rdidx), 32'd100);
    check("pre_rst_de", 32'(de), 32'h1);
    check("pre_rst_rgb", 32'({red, green, blue}), 32'(rgb_of(cram_m[2])));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
    check("mid_rst_de", 32'(de), 32'h0);
    check("mid_rst_hsync", 32'(hsync), 32'h1);
    check("mid_rst_vsync", 32'(vsync), 32'h1);
    check("mid_rst_start", 32'(lb_if.start), 32'h0);
    check("mid_rst_vline", 32'(lb_if.vline), 32'h0);
    check("mid_rst_rdidx", 32'(lb_if.linebuf_rdidx), 32'd0);
    @(negedge clk);
    check("post_rst_start", 32'(lb_if.start), 32'h1);
    check("post_rst_vline", 32'(lb_if.vline), 32'd1);
    check("post_rst_rdidx", 32'(lb_if.linebuf_rdidx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
